debouncer_multi: RTL and testbench
==================================

Name: debouncer_multi

Overview:
- Parametrised, multi-channel successor to the single-button debouncer.
- Debounces CHANNELS independent raw inputs (buttons/switches) with a two-flop synchroniser per channel.
- Produces a registered clean level plus one-cycle press, release and optional auto-repeat pulses.
- Sits between the board pins and the game-control logic (paddle up/down, start, pause).

Parameters:
- CHANNELS, 4, number of independent input channels (>=1).
- DEBOUNCE_CNT, 500000, stability window in clk cycles (~10 ms at 50 MHz); >=1.
- REPEAT_EN, 0, 1 enables auto-repeat pulses while a channel is held.
- REPEAT_DELAY, 25000000, cycles from press pulse to first repeat pulse; >=1.
- REPEAT_PERIOD, 5000000, cycles between subsequent repeat pulses; >=1.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- raw  input  CHANNELS  asynchronous raw inputs; bit i is channel i.
- q  output  CHANNELS  debounced level, registered.
- rise  output  CHANNELS  one-cycle pulse when q goes 0->1.
- fall  output  CHANNELS  one-cycle pulse when q goes 1->0.
- rpt  output  CHANNELS  one-cycle auto-repeat pulse; constant 0 when REPEAT_EN=0.

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high (reset). Reset is sampled only on the rising clk edge.
- Reset:
  - synchroniser flops, q, rise, fall, rpt all 0;
  - every channel state is STABLE_0; all counters 0.
  - Reset mid-operation aborts any pending transition with no pulse.
- Synchroniser: raw[i] passes through two flops to give s[i]; 2 cycles of latency.
- Per-channel state machine: STABLE_0, TO_1, STABLE_1, TO_0. Debounce counter width is ceil(log2(DEBOUNCE_CNT+1)).
- STABLE_0 (q=0):
  - s=1 -> TO_1, cnt <= DEBOUNCE_CNT-1.
- TO_1 (q=0):
  - s=0 -> STABLE_0 (bounce rejected, no pulse);
  - else cnt==0 -> STABLE_1, q<=1, rise<=1 for one cycle, rcnt <= REPEAT_DELAY-1;
  - else cnt <= cnt-1.
- STABLE_1 (q=1):
  - s=0 -> TO_0, cnt <= DEBOUNCE_CNT-1;
  - else repeat logic runs.
- TO_0 (q=1):
  - s=1 -> STABLE_1 (rcnt unchanged);
  - else cnt==0 -> STABLE_0, q<=0, fall<=1 for one cycle;
  - else cnt <= cnt-1.
- Latency: q (and rise/fall) changes DEBOUNCE_CNT+1 cycles after s first shows the new value and stays stable. That is DEBOUNCE_CNT+3 cycles after raw is first sampled.
- Glitch rejection: any opposite sample during TO_x returns to the prior stable state. The counter reloads in full on the next attempt.
- Repeat (REPEAT_EN=1, STABLE_1 only):
  - rcnt==0 -> rpt<=1 for one cycle, rcnt <= REPEAT_PERIOD-1;
  - else rcnt <= rcnt-1.
  - rcnt is frozen in TO_0, so a release bounce does not reset the repeat schedule.
  - Timing: first rpt asserts REPEAT_DELAY cycles after the rise cycle, then every REPEAT_PERIOD cycles.
  - rcnt width: ceil(log2(max(REPEAT_DELAY,REPEAT_PERIOD)+1)).
- Pulse exclusivity: rise, fall and rpt are mutually exclusive per channel. Each is high for exactly one cycle and is 0 in all other cycles.
- Channels are fully independent; simultaneous events on different channels each produce their own pulses in the same cycle.
- raw held high through reset release: treated as a new press; rise fires DEBOUNCE_CNT+3 cycles after reset deasserts.
- Counters never wrap: cnt and rcnt only decrement from a reload value to 0.

Test Plan:
- Bench parameters: CHANNELS=2, DEBOUNCE_CNT=4, REPEAT_EN=1, REPEAT_DELAY=10, REPEAT_PERIOD=3.
- Reset: assert reset 3 cycles with raw=2'b11 -> q, rise, fall, rpt all 0 during reset. After deassert, rise[0] and rise[1] pulse together on cycle 7, and q=2'b11 from then on.
- Clean press/release: raw[0] 0->1 at cycle 0, held -> rise[0] for one cycle at cycle 7, q[0]=1. Drop raw[0] at cycle 30 -> fall[0] at cycle 37, q[0]=0. No fall[1].
- Bounce rejection: raw[0] toggles 1,0,1,0 every 2 cycles, then stays 1 -> no pulse during toggling. rise[0] fires exactly 7 cycles after the final 0->1.
- Auto-repeat: hold raw[1] -> rise[1] at cycle T, rpt[1] at T+10, T+13, T+16.
  - Release bounce of 2 low cycles at T+11 -> next rpt still at T+13 plus the frozen cycles. q[1] stays 1.
- Reset mid-transition: reset asserted while channel 0 is in TO_1 with cnt=2 -> no rise. After reset, with raw still 1, rise fires 7 cycles later.
- REPEAT_EN=0 build: hold raw[0] for 100 cycles -> rpt stays 2'b00; a single rise only.

Source files
------------

// File: rtl/debouncer_multi_if.sv
// debouncer_multi_if: groups the per-channel pins of debouncer_multi.
//   raw  - asynchronous raw button/switch inputs, bit i is channel i
//   q    - debounced level, registered
//   rise - one-cycle pulse when q goes 0->1
//   fall - one-cycle pulse when q goes 1->0
//   rpt  - one-cycle auto-repeat pulse while a channel is held
// The master modport is the board/pin side and the slave modport is the debouncer.
interface debouncer_multi_if #(
    parameter int unsigned CHANNELS = 4
) ();
    logic [CHANNELS-1:0] raw;
    logic [CHANNELS-1:0] q;
    logic [CHANNELS-1:0] rise;
    logic [CHANNELS-1:0] fall;
    logic [CHANNELS-1:0] rpt;

    modport master (
        output raw,
        input  q,
        input  rise,
        input  fall,
        input  rpt
    );

    modport slave (
        input  raw,
        output q,
        output rise,
        output fall,
        output rpt
    );
endinterface

// File: rtl/debouncer_multi.sv
// debouncer_multi: multi-channel button/switch debouncer with optional auto-repeat.
//   clk   - system clock, all logic on the rising edge
//   reset - synchronous, active-high reset
//   bus   - debouncer_multi_if slave: raw in; q, rise, fall, rpt out
// Each channel runs a two-flop synchroniser followed by a four-state FSM that
// requires DEBOUNCE_CNT+1 consecutive equal samples before changing q.
module debouncer_multi #(
    parameter int unsigned CHANNELS      = 4,
    parameter int unsigned DEBOUNCE_CNT  = 500000,
    parameter int unsigned REPEAT_EN     = 0,
    parameter int unsigned REPEAT_DELAY  = 25000000,
    parameter int unsigned REPEAT_PERIOD = 5000000
) (
    input logic              clk,
    input logic              reset,
    debouncer_multi_if.slave bus
);

    localparam int unsigned CntW   = $clog2(DEBOUNCE_CNT + 1);
    localparam int unsigned RptMax = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY
                                                                    : REPEAT_PERIOD;
    localparam int unsigned RcntW  = $clog2(RptMax + 1);

    localparam logic [CntW-1:0]  CntLoad    = CntW'(DEBOUNCE_CNT - 1);
    localparam logic [RcntW-1:0] RcntDelay  = RcntW'(REPEAT_DELAY - 1);
    localparam logic [RcntW-1:0] RcntPeriod = RcntW'(REPEAT_PERIOD - 1);

    typedef enum logic [1:0] {
        StStable0,
        StTo1,
        StStable1,
        StTo0
    } state_e;

    // Two-flop synchroniser for every channel.
    logic [CHANNELS-1:0] sync1_q;
    logic [CHANNELS-1:0] sync2_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= bus.raw;
            sync2_q <= sync1_q;
        end
    end

    logic [CHANNELS-1:0] q_vec;
    logic [CHANNELS-1:0] rise_vec;
    logic [CHANNELS-1:0] fall_vec;
    logic [CHANNELS-1:0] rpt_vec;

    for (genvar i = 0; i < CHANNELS; i++) begin : gen_ch
        state_e           state_q, state_d;
        logic [CntW-1:0]  cnt_q, cnt_d;
        logic [RcntW-1:0] rcnt_q, rcnt_d;
        logic             q_q, q_d;
        logic             rise_q, rise_d;
        logic             fall_q, fall_d;
        logic             rpt_q, rpt_d;
        logic             s;

        assign s = sync2_q[i];

        always_comb begin
            state_d = state_q;
            cnt_d   = cnt_q;
            rcnt_d  = rcnt_q;
            q_d     = q_q;
            rise_d  = 1'b0;
            fall_d  = 1'b0;
            rpt_d   = 1'b0;
            unique case (state_q)
                StStable0: begin
                    if (s) begin
                        state_d = StTo1;
                        cnt_d   = CntLoad;
                    end
                end
                StTo1: begin
                    if (!s) begin
                        // Bounce: drop the attempt, counter reloads on the next one.
                        state_d = StStable0;
                    end else if (cnt_q == '0) begin
                        state_d = StStable1;
                        q_d     = 1'b1;
                        rise_d  = 1'b1;
                        rcnt_d  = RcntDelay;
                    end else begin
                        cnt_d = cnt_q - CntW'(1);
                    end
                end
                StStable1: begin
                    if (!s) begin
                        state_d = StTo0;
                        cnt_d   = CntLoad;
                    end else if (REPEAT_EN != 0) begin
                        if (rcnt_q == '0) begin
                            rpt_d  = 1'b1;
                            rcnt_d = RcntPeriod;
                        end else begin
                            rcnt_d = rcnt_q - RcntW'(1);
                        end
                    end
                end
                StTo0: begin
                    // rcnt is left alone here so a release bounce keeps the repeat schedule.
                    if (s) begin
                        state_d = StStable1;
                    end else if (cnt_q == '0) begin
                        state_d = StStable0;
                        q_d     = 1'b0;
                        fall_d  = 1'b1;
                    end else begin
                        cnt_d = cnt_q - CntW'(1);
                    end
                end
                default: begin
                    state_d = StStable0;
                end
            endcase
        end

        always_ff @(posedge clk) begin
            if (reset) begin
                state_q <= StStable0;
                cnt_q   <= '0;
                rcnt_q  <= '0;
                q_q     <= 1'b0;
                rise_q  <= 1'b0;
                fall_q  <= 1'b0;
                rpt_q   <= 1'b0;
            end else begin
                state_q <= state_d;
                cnt_q   <= cnt_d;
                rcnt_q  <= rcnt_d;
                q_q     <= q_d;
                rise_q  <= rise_d;
                fall_q  <= fall_d;
                rpt_q   <= rpt_d;
            end
        end

        assign q_vec[i]    = q_q;
        assign rise_vec[i] = rise_q;
        assign fall_vec[i] = fall_q;
        assign rpt_vec[i]  = rpt_q;
    end

    assign bus.q    = q_vec;
    assign bus.rise = rise_vec;
    assign bus.fall = fall_vec;
    assign bus.rpt  = rpt_vec;

endmodule

// File: tb/tb_debouncer_multi.sv
// tb_debouncer_multi: self-checking bench for debouncer_multi.
// dut_a: CHANNELS=2, DEBOUNCE_CNT=4, REPEAT_EN=1, REPEAT_DELAY=10, REPEAT_PERIOD=3.
// dut_b: same but REPEAT_EN=0.
// Expected pulses are pushed to exp_q as stimulus is driven; a negedge monitor
// pushes observed pulses of dut_a to obs_q and each test drains both in order.
module tb_debouncer_multi;

    localparam int unsigned Ch = 2;

    typedef struct {
        int cyc;
        int kind;  // 0 rise, 1 fall, 2 rpt
        int ch;
    } ev_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;
    bit   mon_en = 1'b0;
    ev_t  exp_q[$];
    ev_t  obs_q[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    debouncer_multi_if #(.CHANNELS(Ch)) bus_a ();
    debouncer_multi_if #(.CHANNELS(Ch)) bus_b ();

    debouncer_multi #(
        .CHANNELS     (Ch),
        .DEBOUNCE_CNT (4),
        .REPEAT_EN    (1),
        .REPEAT_DELAY (10),
        .REPEAT_PERIOD(3)
    ) dut_a (
        .clk  (clk),
        .reset(reset),
        .bus  (bus_a)
    );

    debouncer_multi #(
        .CHANNELS     (Ch),
        .DEBOUNCE_CNT (4),
        .REPEAT_EN    (0),
        .REPEAT_DELAY (10),
        .REPEAT_PERIOD(3)
    ) dut_b (
        .clk  (clk),
        .reset(reset),
        .bus  (bus_b)
    );

    function automatic ev_t mk(int c, int k, int ch);
        ev_t e;
        e.cyc  = c;
        e.kind = k;
        e.ch   = ch;
        return e;
    endfunction

    always @(negedge clk) begin
        if (mon_en) begin
            for (int c = 0; c < int'(Ch); c++) begin
                if (bus_a.rise[c] === 1'b1) obs_q.push_back(mk(cyc, 0, c));
                if (bus_a.fall[c] === 1'b1) obs_q.push_back(mk(cyc, 1, c));
                if (bus_a.rpt[c] === 1'b1)  obs_q.push_back(mk(cyc, 2, c));
            end
        end
    end

    // Leaves the bench 1 time unit after the rising edge that starts cycle c.
    task automatic wait_to(input int c);
        while (cyc < c) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset();
        int e;
        bus_a.raw = 2'b11;
        bus_b.raw = 2'b00;
        mon_en    = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            @(negedge clk);
            n_checks++;
            if ({bus_a.q, bus_a.rise, bus_a.fall, bus_a.rpt} !== 8'h00) begin
                n_fail++;
                $display("FAIL reset_outputs: cycle %0d q/rise/fall/rpt=%b required 00000000",
                         cyc, {bus_a.q, bus_a.rise, bus_a.fall, bus_a.rpt});
            end
        end
        reset = 1'b0;
        e = cyc;
        exp_q.push_back(mk(e + 7, 0, 0));
        exp_q.push_back(mk(e + 7, 0, 1));
        wait_to(e + 8);
        @(negedge clk);
        n_checks++;
        if (bus_a.q !== 2'b11) begin
            n_fail++;
            $display("FAIL reset_release_q: q=%b required 11", bus_a.q);
        end
        wait_to(e + 9);
        bus_a.raw = 2'b00;
        exp_q.push_back(mk(e + 16, 1, 0));
        exp_q.push_back(mk(e + 16, 1, 1));
        wait_to(e + 22);
        @(negedge clk);
        while (exp_q.size() > 0) begin
            ev_t x, o;
            x = exp_q.pop_front();
            n_checks++;
            if (obs_q.size() == 0) begin
                n_fail++;
                $display("FAIL reset_pulse: missing pulse, required kind %0d ch %0d cycle %0d",
                         x.kind, x.ch, x.cyc);
            end else begin
                o = obs_q.pop_front();
                if (o.cyc !== x.cyc || o.kind !== x.kind || o.ch !== x.ch) begin
                    n_fail++;
                    $display("FAIL reset_pulse: got kind %0d ch %0d cycle %0d, required kind %0d ch %0d cycle %0d",
                             o.kind, o.ch, o.cyc, x.kind, x.ch, x.cyc);
                end
            end
        end
        while (obs_q.size() > 0) begin
            ev_t o;
            o = obs_q.pop_front();
            n_checks++;
            n_fail++;
            $display("FAIL reset_extra: got kind %0d ch %0d cycle %0d, required no pulse",
                     o.kind, o.ch, o.cyc);
        end
    endtask

    task automatic test_press_release();
        int t;
        wait_to(cyc + 1);
        t = cyc;
        bus_a.raw[0] = 1'b1;
        exp_q.push_back(mk(t + 7, 0, 0));
        for (int r = t + 17; r <= t + 32; r += 3) exp_q.push_back(mk(r, 2, 0));
        wait_to(t + 8);
        @(negedge clk);
        n_checks++;
        if (bus_a.q !== 2'b01) begin
            n_fail++;
            $display("FAIL press_q: q=%b required 01", bus_a.q);
        end
        wait_to(t + 30);
        bus_a.raw[0] = 1'b0;
        exp_q.push_back(mk(t + 37, 1, 0));
        wait_to(t + 40);
        @(negedge clk);
        n_checks++;
        if (bus_a.q !== 2'b00) begin
            n_fail++;
            $display("FAIL release_q: q=%b required 00", bus_a.q);
        end
        while (exp_q.size() > 0) begin
            ev_t x, o;
            x = exp_q.pop_front();
            n_checks++;
            if (obs_q.size() == 0) begin
                n_fail++;
                $display("FAIL press_pulse: missing pulse, required kind %0d ch %0d cycle %0d",
                         x.kind, x.ch, x.cyc);
            end else begin
                o = obs_q.pop_front();
                if (o.cyc !== x.cyc || o.kind !== x.kind || o.ch !== x.ch) begin
                    n_fail++;
                    $display("FAIL press_pulse: got kind %0d ch %0d cycle %0d, required kind %0d ch %0d cycle %0d",
                             o.kind, o.ch, o.cyc, x.kind, x.ch, x.cyc);
                end
            end
        end
        while (obs_q.size() > 0) begin
            ev_t o;
            o = obs_q.pop_front();
            n_checks++;
            n_fail++;
            $display("FAIL press_extra: got kind %0d ch %0d cycle %0d, required no pulse",
                     o.kind, o.ch, o.cyc);
        end
    endtask

    task automatic test_bounce();
        int t;
        wait_to(cyc + 1);
        t = cyc;
        for (int k = 0; k < 4; k++) begin
            wait_to(t + 2 * k);
            bus_a.raw[0] = (k % 2 == 0);
        end
        wait_to(t + 8);
        bus_a.raw[0] = 1'b1;
        exp_q.push_back(mk(t + 15, 0, 0));
        wait_to(t + 20);
        bus_a.raw[0] = 1'b0;
        exp_q.push_back(mk(t + 27, 1, 0));
        wait_to(t + 32);
        @(negedge clk);
        while (exp_q.size() > 0) begin
            ev_t x, o;
            x = exp_q.pop_front();
            n_checks++;
            if (obs_q.size() == 0) begin
                n_fail++;
                $display("FAIL bounce_pulse: missing pulse, required kind %0d ch %0d cycle %0d",
                         x.kind, x.ch, x.cyc);
            end else begin
                o = obs_q.pop_front();
                if (o.cyc !== x.cyc || o.kind !== x.kind || o.ch !== x.ch) begin
                    n_fail++;
                    $display("FAIL bounce_pulse: got kind %0d ch %0d cycle %0d, required kind %0d ch %0d cycle %0d",
                             o.kind, o.ch, o.cyc, x.kind, x.ch, x.cyc);
                end
            end
        end
        while (obs_q.size() > 0) begin
            ev_t o;
            o = obs_q.pop_front();
            n_checks++;
            n_fail++;
            $display("FAIL bounce_extra: got kind %0d ch %0d cycle %0d, required no pulse",
                     o.kind, o.ch, o.cyc);
        end
    endtask

    task automatic test_repeat();
        int t;
        int rt;
        wait_to(cyc + 1);
        t  = cyc;
        rt = t + 7;
        bus_a.raw[1] = 1'b1;
        exp_q.push_back(mk(rt, 0, 1));
        exp_q.push_back(mk(rt + 10, 2, 1));
        // Two low cycles reach the FSM at rt+11/rt+12; rcnt freezes for 3 cycles.
        wait_to(rt + 8);
        bus_a.raw[1] = 1'b0;
        wait_to(rt + 10);
        bus_a.raw[1] = 1'b1;
        exp_q.push_back(mk(rt + 16, 2, 1));
        exp_q.push_back(mk(rt + 19, 2, 1));
        exp_q.push_back(mk(rt + 22, 2, 1));
        for (int k = 11; k <= 15; k++) begin
            wait_to(rt + k);
            @(negedge clk);
            n_checks++;
            if (bus_a.q[1] !== 1'b1) begin
                n_fail++;
                $display("FAIL repeat_hold_q: cycle %0d q[1]=%b required 1", cyc, bus_a.q[1]);
            end
        end
        wait_to(rt + 20);
        bus_a.raw[1] = 1'b0;
        exp_q.push_back(mk(rt + 27, 1, 1));
        wait_to(rt + 32);
        @(negedge clk);
        while (exp_q.size() > 0) begin
            ev_t x, o;
            x = exp_q.pop_front();
            n_checks++;
            if (obs_q.size() == 0) begin
                n_fail++;
                $display("FAIL repeat_pulse: missing pulse, required kind %0d ch %0d cycle %0d",
                         x.kind, x.ch, x.cyc);
            end else begin
                o = obs_q.pop_front();
                if (o.cyc !== x.cyc || o.kind !== x.kind || o.ch !== x.ch) begin
                    n_fail++;
                    $display("FAIL repeat_pulse: got kind %0d ch %0d cycle %0d, required kind %0d ch %0d cycle %0d",
                             o.kind, o.ch, o.cyc, x.kind, x.ch, x.cyc);
                end
            end
        end
        while (obs_q.size() > 0) begin
            ev_t o;
            o = obs_q.pop_front();
            n_checks++;
            n_fail++;
            $display("FAIL repeat_extra: got kind %0d ch %0d cycle %0d, required no pulse",
                     o.kind, o.ch, o.cyc);
        end
    endtask

    task automatic test_reset_mid();
        int c;
        wait_to(cyc + 1);
        c = cyc;
        bus_a.raw[0] = 1'b1;
        // FSM enters TO_1 at c+3 (cnt=3); cnt is 2 after c+4.
        wait_to(c + 4);
        reset = 1'b1;
        @(negedge clk);
        wait_to(c + 5);
        reset = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({bus_a.q, bus_a.rise, bus_a.fall, bus_a.rpt} !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_mid_outputs: q/rise/fall/rpt=%b required 00000000",
                     {bus_a.q, bus_a.rise, bus_a.fall, bus_a.rpt});
        end
        exp_q.push_back(mk(c + 12, 0, 0));
        wait_to(c + 14);
        bus_a.raw[0] = 1'b0;
        exp_q.push_back(mk(c + 21, 1, 0));
        wait_to(c + 25);
        @(negedge clk);
        while (exp_q.size() > 0) begin
            ev_t x, o;
            x = exp_q.pop_front();
            n_checks++;
            if (obs_q.size() == 0) begin
                n_fail++;
                $display("FAIL reset_mid_pulse: missing pulse, required kind %0d ch %0d cycle %0d",
                         x.kind, x.ch, x.cyc);
            end else begin
                o = obs_q.pop_front();
                if (o.cyc !== x.cyc || o.kind !== x.kind || o.ch !== x.ch) begin
                    n_fail++;
                    $display("FAIL reset_mid_pulse: got kind %0d ch %0d cycle %0d, required kind %0d ch %0d cycle %0d",
                             o.kind, o.ch, o.cyc, x.kind, x.ch, x.cyc);
                end
            end
        end
        while (obs_q.size() > 0) begin
            ev_t o;
            o = obs_q.pop_front();
            n_checks++;
            n_fail++;
            $display("FAIL reset_mid_extra: got kind %0d ch %0d cycle %0d, required no pulse",
                     o.kind, o.ch, o.cyc);
        end
    endtask

    task automatic test_no_repeat();
        int t;
        int rise_cnt = 0;
        int rise_cyc = -1;
        int rpt_cnt = 0;
        int fall_cnt = 0;
        wait_to(cyc + 1);
        t = cyc;
        bus_b.raw[0] = 1'b1;
        for (int k = 1; k <= 100; k++) begin
            @(negedge clk);
            if (bus_b.rise !== 2'b00) begin
                rise_cnt++;
                rise_cyc = cyc;
            end
            if (bus_b.rpt !== 2'b00) rpt_cnt++;
            @(posedge clk);
        end
        n_checks++;
        if (rise_cnt !== 1) begin
            n_fail++;
            $display("FAIL norpt_rise_count: got %0d required 1", rise_cnt);
        end
        n_checks++;
        if (rise_cyc !== t + 7) begin
            n_fail++;
            $display("FAIL norpt_rise_cycle: got %0d required %0d", rise_cyc, t + 7);
        end
        n_checks++;
        if (rpt_cnt !== 0) begin
            n_fail++;
            $display("FAIL norpt_rpt: got %0d rpt cycles required 0", rpt_cnt);
        end
        n_checks++;
        if (bus_b.q !== 2'b01) begin
            n_fail++;
            $display("FAIL norpt_q: q=%b required 01", bus_b.q);
        end
        #1;
        bus_b.raw[0] = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            if (bus_b.fall !== 2'b00) fall_cnt++;
            @(posedge clk);
        end
        n_checks++;
        if (fall_cnt !== 1 || bus_b.q !== 2'b00) begin
            n_fail++;
            $display("FAIL norpt_release: falls=%0d q=%b required 1 fall and q=00",
                     fall_cnt, bus_b.q);
        end
        n_checks++;
        if (obs_q.size() !== 0) begin
            n_fail++;
            $display("FAIL norpt_dut_a_quiet: %0d pulses on dut_a required 0", obs_q.size());
            obs_q.delete();
        end
    endtask

    initial begin
        bus_a.raw = '0;
        bus_b.raw = '0;
        test_reset();
        test_press_release();
        test_bounce();
        test_repeat();
        test_reset_mid();
        test_no_repeat();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
